seg7_scan_reader: RTL and testbench

//  Reads a multiplexed, active-low 7-segment display bus (seg_n = {g,f,e,d,c,b,a}, an_n one-cold digit

---
 rtl/seg7_pkg.sv | 37 +++
 rtl/seg7_glyph_decode.sv | 44 ++++
 rtl/seg7_scan_reader.sv | 229 ++++++++++++++++++++++
 tb/tb_seg7_scan_reader.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module  : seg7_pkg
// Purpose : Shared definitions for the 7-segment scan reader: the sixteen
//           active-low hex glyph codes ({g,f,e,d,c,b,a}, bit0 = a) and the
//           scan FSM state type.
// Revision: 1.0 - initial release
// ============================================================================
package seg7_pkg;

    // Active-low glyph codes, one per hex digit.
    localparam logic [6:0] SEG7_0 = 7'h40;
    localparam logic [6:0] SEG7_1 = 7'h79;
    localparam logic [6:0] SEG7_2 = 7'h24;
    localparam logic [6:0] SEG7_3 = 7'h30;
    localparam logic [6:0] SEG7_4 = 7'h19;
    localparam logic [6:0] SEG7_5 = 7'h12;
    localparam logic [6:0] SEG7_6 = 7'h02;
    localparam logic [6:0] SEG7_7 = 7'h78;
    localparam logic [6:0] SEG7_8 = 7'h00;
    localparam logic [6:0] SEG7_9 = 7'h10;
    localparam logic [6:0] SEG7_A = 7'h08;
    localparam logic [6:0] SEG7_B = 7'h03;
    localparam logic [6:0] SEG7_C = 7'h46;
    localparam logic [6:0] SEG7_D = 7'h21;
    localparam logic [6:0] SEG7_E = 7'h06;
    localparam logic [6:0] SEG7_F = 7'h0E;

    // Scan FSM states, explicitly encoded.
    typedef enum logic [1:0] {
        BLANK  = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } seg7_state_t;

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/seg7_glyph_decode.sv
`default_nettype none
// ============================================================================
// Module  : seg7_glyph_decode
// Purpose : Combinational lookup of an active-low 7-segment code into its hex
//           nibble. Codes outside the sixteen hex glyphs report ok = 0.
// Ports   : seg_n  in  7  segment code, active low, bit0 = a .. bit6 = g
//           ok     out 1  code is a valid hex glyph
//           nibble out 4  decoded value (0 when ok = 0)
// Revision: 1.0 - initial release
// ============================================================================
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg_n,
    output logic       ok,
    output logic [3:0] nibble
);

    always_comb begin
        ok     = 1'b1;
        nibble = 4'h0;
        case (seg_n)
            SEG7_0:  nibble = 4'h0;
            SEG7_1:  nibble = 4'h1;
            SEG7_2:  nibble = 4'h2;
            SEG7_3:  nibble = 4'h3;
            SEG7_4:  nibble = 4'h4;
            SEG7_5:  nibble = 4'h5;
            SEG7_6:  nibble = 4'h6;
            SEG7_7:  nibble = 4'h7;
            SEG7_8:  nibble = 4'h8;
            SEG7_9:  nibble = 4'h9;
            SEG7_A:  nibble = 4'hA;
            SEG7_B:  nibble = 4'hB;
            SEG7_C:  nibble = 4'hC;
            SEG7_D:  nibble = 4'hD;
            SEG7_E:  nibble = 4'hE;
            SEG7_F:  nibble = 4'hF;
            default: ok     = 1'b0;
        endcase
    end

endmodule : seg7_glyph_decode
`default_nettype wire

// File: rtl/seg7_scan_reader.sv
`default_nettype none
// ============================================================================
// Module  : seg7_scan_reader
// Purpose : Receive end of a multiplexed active-low 7-segment display bus.
//           Each digit's pattern is sampled once it has been steady for
//           STABLE cycles, decoded to a nibble and stored in a per-digit
//           slot. When every digit has been seen, the slots are published
//           on value with a one-cycle valid pulse. Non-hex patterns raise a
//           one-cycle pat_err pulse and leave the slot untouched.
// Params  : NDIG   number of multiplexed digits (1..8)
//           STABLE cycles of unchanged input required before sampling (>=1)
// Ports   : clk      in  1       system clock, rising edge
//           rst      in  1       asynchronous reset, active high
//           seg_n    in  7       segment lines, active low, bit0 = a
//           an_n     in  NDIG    digit selects, active low, one-cold
//           dp_n     in  1       decimal point, active low  (SEG7_DP_EN)
//           value    out 4*NDIG  last complete frame, digit i at [4i+3:4i]
//           dp_out   out NDIG    decimal points of that frame (SEG7_DP_EN)
//           valid    out 1       pulse: value holds a new frame
//           pat_err  out 1       pulse: stable pattern is not a hex glyph
// Config  : define SEG7_DP_EN to add decimal-point capture (dp_n/dp_out).
// Revision: 1.0 - initial release
// ============================================================================
module seg7_scan_reader
    import seg7_pkg::*;
#(
    parameter int NDIG   = 4,
    parameter int STABLE = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [6:0]        seg_n,
    input  logic [NDIG-1:0]   an_n,
`ifdef SEG7_DP_EN
    input  logic              dp_n,
    output logic [NDIG-1:0]   dp_out,
`endif
    output logic [4*NDIG-1:0] value,
    output logic              valid,
    output logic              pat_err
);

    localparam int              CNT_W     = $clog2(STABLE + 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(STABLE);
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);
    localparam logic [NDIG-1:0]  c_SEL_ONE = NDIG'(1);

    // Input sampling register plus one older copy for change detection.
    // Reset to "all off / no digit selected" so the bus looks blank.
    logic [6:0]      r_seg;
    logic [6:0]      r_seg_d;
    logic [NDIG-1:0] r_an;
    logic [NDIG-1:0] r_an_d;

    seg7_state_t      r_state;
    seg7_state_t      w_state_nx;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nx;

    logic [4*NDIG-1:0] r_slots;
    logic [NDIG-1:0]   r_seen;
    logic [4*NDIG-1:0] r_value;
    logic              r_valid;
    logic              r_pat_err;

    logic [NDIG-1:0] w_sel;
    logic            w_one_cold;
    logic            w_changed;
    logic            w_sample;
    logic            w_dec_ok;
    logic [3:0]      w_nibble;
    logic            w_frame_done;

`ifdef SEG7_DP_EN
    logic            r_dp;
    logic            r_dp_d;
    logic [NDIG-1:0] r_dp_slots;
    logic [NDIG-1:0] r_dp_out;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg   <= '1;
            r_seg_d <= '1;
            r_an    <= '1;
            r_an_d  <= '1;
        end else begin
            r_seg   <= seg_n;
            r_seg_d <= r_seg;
            r_an    <= an_n;
            r_an_d  <= r_an;
        end
    end

    // Selected digit as a one-hot vector; valid only when exactly one bit set.
    assign w_sel      = ~r_an;
    assign w_one_cold = (w_sel != '0) && ((w_sel & (w_sel - c_SEL_ONE)) == '0);

`ifdef SEG7_DP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dp   <= 1'b1;
            r_dp_d <= 1'b1;
        end else begin
            r_dp   <= dp_n;
            r_dp_d <= r_dp;
        end
    end

    assign w_changed = (r_seg != r_seg_d) || (r_an != r_an_d) || (r_dp != r_dp_d);
`else
    assign w_changed = (r_seg != r_seg_d) || (r_an != r_an_d);
`endif

    seg7_glyph_decode u_glyph_decode (
        .seg_n  (r_seg),
        .ok     (w_dec_ok),
        .nibble (w_nibble)
    );

    // Next-state logic. A change always restarts the stability count, so a
    // pattern is sampled only after STABLE+1 identical register samples.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_sample   = 1'b0;
        case (r_state)
            BLANK: begin
                if (w_one_cold) begin
                    w_state_nx = SETTLE;
                    w_cnt_nx   = c_CNT_ONE;
                end else begin
                    w_cnt_nx   = '0;
                end
            end
            SETTLE: begin
                if (w_changed) begin
                    w_state_nx = w_one_cold ? SETTLE : BLANK;
                    w_cnt_nx   = w_one_cold ? c_CNT_ONE : '0;
                end else if (r_cnt == c_CNT_MAX) begin
                    w_sample   = 1'b1;
                    w_state_nx = HOLD;
                end else begin
                    w_cnt_nx   = r_cnt + c_CNT_ONE;
                end
            end
            HOLD: begin
                // Already sampled this pattern; only a change re-arms.
                if (w_changed) begin
                    w_state_nx = w_one_cold ? SETTLE : BLANK;
                    w_cnt_nx   = w_one_cold ? c_CNT_ONE : '0;
                end
            end
            default: begin
                w_state_nx = BLANK;
                w_cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= BLANK;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    // A sample cannot coincide with frame completion: the sample that filled
    // the mask leaves the FSM in HOLD for at least one cycle.
    assign w_frame_done = &r_seen;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slots   <= '0;
            r_seen    <= '0;
            r_value   <= '0;
            r_valid   <= 1'b0;
            r_pat_err <= 1'b0;
        end else begin
            r_valid   <= w_frame_done;
            r_pat_err <= w_sample & ~w_dec_ok;
            if (w_frame_done) begin
                r_value <= r_slots;
                r_seen  <= '0;
            end else if (w_sample && w_dec_ok) begin
                r_seen  <= r_seen | w_sel;
            end
            if (w_sample && w_dec_ok) begin
                for (int i = 0; i < NDIG; i++) begin
                    if (w_sel[i]) begin
                        r_slots[4*i +: 4] <= w_nibble;
                    end
                end
            end
        end
    end

`ifdef SEG7_DP_EN
    // Stored as "point lit" (1 = on) alongside each nibble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dp_slots <= '0;
            r_dp_out   <= '0;
        end else begin
            if (w_frame_done) begin
                r_dp_out <= r_dp_slots;
            end
            if (w_sample && w_dec_ok) begin
                for (int i = 0; i < NDIG; i++) begin
                    if (w_sel[i]) begin
                        r_dp_slots[i] <= ~r_dp;
                    end
                end
            end
        end
    end

    assign dp_out = r_dp_out;
`endif

    assign value   = r_value;
    assign valid   = r_valid;
    assign pat_err = r_pat_err;

endmodule : seg7_scan_reader
`default_nettype wire

// File: tb/tb_seg7_scan_reader.sv
`default_nettype none
// ============================================================================
// Module  : tb_seg7_scan_reader
// Purpose : Self-checking bench for seg7_scan_reader (NDIG=4, STABLE=3).
//           A behavioural model tracks how long each driven pattern has been
//           steady and when frames complete; outputs are compared against it
//           every cycle, plus literal expectations for each scenario.
// Revision: 1.0 - initial release
// ============================================================================
module tb_seg7_scan_reader;

    localparam int NDIG   = 4;
    localparam int STABLE = 3;

    logic            clk   = 1'b0;
    logic            rst   = 1'b1;
    logic [6:0]      seg_n = 7'h7F;
    logic [NDIG-1:0] an_n  = 4'hF;
    logic [15:0]     value;
    logic            valid;
    logic            pat_err;
`ifdef SEG7_DP_EN
    logic            dp_n = 1'b1;
    logic [NDIG-1:0] dp_out;
`endif

    always #5 clk = ~clk;

    seg7_scan_reader #(.NDIG(NDIG), .STABLE(STABLE)) dut (
        .clk     (clk),
        .rst     (rst),
        .seg_n   (seg_n),
        .an_n    (an_n),
`ifdef SEG7_DP_EN
        .dp_n    (dp_n),
        .dp_out  (dp_out),
`endif
        .value   (value),
        .valid   (valid),
        .pat_err (pat_err)
    );

    int checks = 0;
    int errors = 0;
    int n_valid = 0;
    int n_perr  = 0;

    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lookup(input logic [6:0] s);
        for (int k = 0; k < 16; k++) begin
            if (glyph[k] == s) return k;
        end
        return -1;
    endfunction

    function automatic int one_cold_idx(input logic [3:0] a);
        int lows;
        int idx;
        lows = 0;
        idx  = -1;
        for (int k = 0; k < 4; k++) begin
            if (!a[k]) begin
                lows++;
                idx = k;
            end
        end
        return (lows == 1) ? idx : -1;
    endfunction

    // ---------------- behavioural model ----------------
    // A pattern is taken when the same {an,seg} has been present at
    // STABLE+1 consecutive clock edges; its effect appears one edge later.
    logic [15:0] m_value, m_slots;
    logic [3:0]  m_seen;
    logic        m_valid, m_perr;
    logic        pend_frame, pend_ok, pend_err;
    int          pend_dig;
    logic [3:0]  pend_nib;
    logic [10:0] prev, cur;
    logic        prev_ok;
    int          run_len;

    initial begin
        int d;
        int g;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_value = '0; m_slots = '0; m_seen = '0;
                m_valid = 1'b0; m_perr = 1'b0;
                pend_frame = 1'b0; pend_ok = 1'b0; pend_err = 1'b0;
                pend_dig = 0; pend_nib = '0;
                prev = '0; prev_ok = 1'b0; run_len = 0;
            end else begin
                m_valid = pend_frame;
                m_perr  = pend_err;
                if (pend_frame) begin
                    m_value = m_slots;
                    m_seen  = '0;
                end
                if (pend_ok) begin
                    m_slots[4*pend_dig +: 4] = pend_nib;
                    m_seen[pend_dig] = 1'b1;
                end
                pend_frame = (m_seen == 4'hF);
                pend_ok  = 1'b0;
                pend_err = 1'b0;
                cur = {an_n, seg_n};
                if (prev_ok && cur == prev) run_len++;
                else run_len = 1;
                prev = cur;
                prev_ok = 1'b1;
                d = one_cold_idx(an_n);
                if (d >= 0 && run_len == STABLE + 1) begin
                    g = lookup(seg_n);
                    if (g >= 0) begin
                        pend_ok  = 1'b1;
                        pend_dig = d;
                        pend_nib = 4'(g);
                    end else begin
                        pend_err = 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("value",   32'(value),   32'(m_value));
                chk("valid",   32'(valid),   32'(m_valid));
                chk("pat_err", 32'(pat_err), 32'(m_perr));
                if (valid)   n_valid++;
                if (pat_err) n_perr++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic show(input logic [3:0] an, input logic [6:0] seg, input int n);
        @(negedge clk);
        an_n  = an;
        seg_n = seg;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic frame4(input logic [6:0] g0, input logic [6:0] g1,
                          input logic [6:0] g2, input logic [6:0] g3);
        show(4'b1110, g0, 6);
        show(4'b1101, g1, 6);
        show(4'b1011, g2, 6);
        show(4'b0111, g3, 6);
        show(4'b1111, 7'h7F, 4);
    endtask

    initial begin
        int v0;
        int p0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_value",   32'(value),   32'h0);
        chk("reset_valid",   32'(valid),   32'h0);
        chk("reset_pat_err", 32'(pat_err), 32'h0);
        rst = 1'b0;

        // Basic scan 1,2,3,4
        v0 = n_valid;
        frame4(7'h79, 7'h24, 7'h30, 7'h19);
        chk("scan_value", 32'(value), 32'h4321);
        chk("scan_valid_count", 32'(n_valid - v0), 32'd1);

        // Async reset in the middle of a frame
        show(4'b1110, 7'h40, 6);
        show(4'b1101, 7'h79, 6);
        show(4'b1111, 7'h7F, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_value",   32'(value),   32'h0);
        chk("async_rst_valid",   32'(valid),   32'h0);
        chk("async_rst_pat_err", 32'(pat_err), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        v0 = n_valid;
        show(4'b1011, 7'h24, 6);
        show(4'b0111, 7'h30, 6);
        show(4'b1111, 7'h7F, 4);
        chk("rst_partial_no_valid", 32'(n_valid - v0), 32'd0);
        chk("rst_partial_value",    32'(value),        32'h0);

        // Invalid glyph on digit 1
        v0 = n_valid;
        p0 = n_perr;
        show(4'b1110, 7'h40, 6);
        show(4'b1101, 7'h7F, 6);
        show(4'b1011, 7'h24, 6);
        show(4'b0111, 7'h30, 6);
        show(4'b1111, 7'h7F, 4);
        chk("bad_glyph_perr_count", 32'(n_perr - p0),  32'd1);
        chk("bad_glyph_no_valid",   32'(n_valid - v0), 32'd0);
        show(4'b1101, 7'h79, 6);
        show(4'b1111, 7'h7F, 4);
        chk("bad_glyph_fixed_valid", 32'(n_valid - v0), 32'd1);
        chk("bad_glyph_fixed_value", 32'(value),        32'h3210);

        // Glitching digit 2, then a 4-cycle hold of 'A'
        v0 = n_valid;
        show(4'b1110, 7'h40, 6);
        show(4'b1101, 7'h79, 6);
        show(4'b0111, 7'h19, 6);
        for (int k = 0; k < 5; k++) begin
            show(4'b1011, (k % 2 == 0) ? 7'h12 : 7'h02, 2);
        end
        show(4'b1011, 7'h08, 4);
        show(4'b1111, 7'h7F, 4);
        chk("glitch_value",       32'(value),        32'h4A10);
        chk("glitch_valid_count", 32'(n_valid - v0), 32'd1);

        // Non-one-cold selects
        v0 = n_valid;
        p0 = n_perr;
        show(4'b1001, 7'h79, 10);
        show(4'b1111, 7'h79, 10);
        chk("multi_sel_no_valid", 32'(n_valid - v0), 32'd0);
        chk("multi_sel_no_perr",  32'(n_perr - p0),  32'd0);
        chk("multi_sel_value",    32'(value),        32'h4A10);

        // Full glyph coverage across frames
        frame4(7'h40, 7'h78, 7'h00, 7'h0E);
        chk("frame_F870", 32'(value), 32'hF870);
        frame4(7'h06, 7'h21, 7'h46, 7'h03);
        chk("frame_BCDE", 32'(value), 32'hBCDE);
        frame4(7'h12, 7'h02, 7'h10, 7'h08);
        chk("frame_A965", 32'(value), 32'hA965);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_seg7_scan_reader
`default_nettype wire
